// File: rtl/mcpu_ctrl_if.sv
// Command bundle between the multicycle control FSM and the MCPU datapath.
// master = controller (mcpu_ctrl), slave = datapath/ALU side.
interface mcpu_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ext_zero;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_operation;
  logic       exc;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, overflow, mem_ready,
    output pc_write, ir_write, reg_write, mem_read,
    output mem_write, iord, reg_dst, mem_to_reg,
    output ext_zero, alu_src_a, alu_src_b, pc_source,
    output alu_operation, exc, state
  );

  modport slave (
    output opcode, funct, zero, overflow, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read,
    input  mem_write, iord, reg_dst, mem_to_reg,
    input  ext_zero, alu_src_a, alu_src_b, pc_source,
    input  alu_operation, exc, state
  );
endinterface

// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS control FSM driving the datapath strobes and ALU code.
// Define OVERFLOW_TRAP_EN to trap on signed overflow instead of writing back.
module mcpu_ctrl #(
  parameter logic [1:0] TRAP_VEC_SEL = 2'b11
) (
  input logic         clk,
  input logic         rst,
  mcpu_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [3:0] A_AND  = 4'b0000;
  localparam logic [3:0] A_OR   = 4'b0001;
  localparam logic [3:0] A_ADD  = 4'b0010;
  localparam logic [3:0] A_XOR  = 4'b0011;
  localparam logic [3:0] A_NOR  = 4'b0100;
  localparam logic [3:0] A_SLT  = 4'b0101;
  localparam logic [3:0] A_SUB  = 4'b0110;
  localparam logic [3:0] A_SLTU = 4'b0111;
  localparam logic [3:0] A_SRL  = 4'b1000;
  localparam logic [3:0] A_SLL  = 4'b1001;
  localparam logic [3:0] A_SRA  = 4'b1010;
  localparam logic [3:0] A_MUL  = 4'b1011;
  localparam logic [3:0] A_ADDU = 4'b1100;
  localparam logic [3:0] A_SUBU = 4'b1101;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t     st;
  state_t     dec_next;
  state_t     wb_next;
  logic [3:0] r_op;
  logic [3:0] i_op;
  logic       r_shift;
  logic       i_logic;
  logic       wb_trap;

  always_comb begin
    r_shift = 1'b0;
    unique case (bus.funct)
      6'b100000: r_op = A_ADD;
      6'b100001: r_op = A_ADDU;
      6'b100010: r_op = A_SUB;
      6'b100011: r_op = A_SUBU;
      6'b100100: r_op = A_AND;
      6'b100101: r_op = A_OR;
      6'b100110: r_op = A_XOR;
      6'b100111: r_op = A_NOR;
      6'b101010: r_op = A_SLT;
      6'b101011: r_op = A_SLTU;
      6'b011000: r_op = A_MUL;
      6'b000000: begin r_op = A_SLL; r_shift = 1'b1; end
      6'b000010: begin r_op = A_SRL; r_shift = 1'b1; end
      6'b000011: begin r_op = A_SRA; r_shift = 1'b1; end
      default:   r_op = A_ADD;
    endcase
  end

  always_comb begin
    i_logic = 1'b0;
    unique case (bus.opcode)
      6'b001001: i_op = A_ADDU;
      6'b001010: i_op = A_SLT;
      6'b001011: i_op = A_SLTU;
      6'b001100: begin i_op = A_AND; i_logic = 1'b1; end
      6'b001101: begin i_op = A_OR;  i_logic = 1'b1; end
      6'b001110: begin i_op = A_XOR; i_logic = 1'b1; end
      default:   i_op = A_ADD;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      bus.opcode == OP_R:
        dec_next = S_EXEC;
      bus.opcode == OP_LW,
      bus.opcode == OP_SW:
        dec_next = S_MEM_ADDR;
      bus.opcode == OP_BEQ,
      bus.opcode == OP_BNE:
        dec_next = S_BRANCH;
      bus.opcode == OP_J:
        dec_next = S_JUMP;
      bus.opcode[5:3] == 3'b001 && bus.opcode != 6'b001111:
        dec_next = S_IMM_EXEC;
      default:
        dec_next = S_FETCH;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q;

  // Overflow is captured at the execute step; writeback decides on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (st == S_EXEC) begin
      ovf_q <= bus.overflow & (r_op == A_ADD || r_op == A_SUB);
    end else if (st == S_IMM_EXEC) begin
      ovf_q <= bus.overflow & (bus.opcode == OP_ADDI);
    end
  end

  assign wb_trap = ovf_q;
  assign wb_next = ovf_q ? S_TRAP : S_FETCH;
`else
  assign wb_trap = 1'b0;
  assign wb_next = S_FETCH;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:    if (bus.mem_ready) st <= S_DECODE;
        S_DECODE:   st <= dec_next;
        S_MEM_ADDR:
          st <= (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (bus.mem_ready) st <= S_MEM_WB;
        S_MEM_WR:   if (bus.mem_ready) st <= S_FETCH;
        S_EXEC:     st <= S_R_WB;
        S_IMM_EXEC: st <= S_IMM_WB;
        S_R_WB:     st <= wb_next;
        S_IMM_WB:   st <= wb_next;
        default:    st <= S_FETCH;
      endcase
    end
  end

  // Reset forces every strobe low combinationally, even in FETCH.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ext_zero      = 1'b0;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.alu_operation = A_AND;
    bus.exc           = 1'b0;
    if (!rst) begin
      case (st)
        S_FETCH: begin
          bus.mem_read      = 1'b1;
          bus.alu_src_b     = 2'b01;
          bus.alu_operation = A_ADD;
          bus.pc_write      = bus.mem_ready;
          bus.ir_write      = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b     = 2'b11;
          bus.alu_operation = A_ADD;
        end
        S_MEM_ADDR: begin
          bus.alu_src_a     = 2'b01;
          bus.alu_src_b     = 2'b10;
          bus.alu_operation = A_ADD;
        end
        S_MEM_RD: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a     = r_shift ? 2'b10 : 2'b01;
          bus.alu_operation = r_op;
        end
        S_R_WB: begin
          bus.reg_dst   = 1'b1;
          bus.reg_write = ~wb_trap;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 2'b01;
          bus.alu_operation = A_SUB;
          bus.pc_source     = 2'b01;
          bus.pc_write      = bus.opcode[0] ^ bus.zero;
        end
        S_JUMP: begin
          bus.pc_source = 2'b10;
          bus.pc_write  = 1'b1;
        end
        S_IMM_EXEC: begin
          bus.alu_src_a     = 2'b01;
          bus.alu_src_b     = 2'b10;
          bus.alu_operation = i_op;
          bus.ext_zero      = i_logic;
        end
        S_IMM_WB: begin
          bus.reg_write = ~wb_trap;
        end
        S_TRAP: begin
          bus.pc_source = TRAP_VEC_SEL;
          bus.pc_write  = 1'b1;
          bus.exc       = wb_trap | 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = st;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: vector table, hand sequences, and
// randomized instructions against a path-level reference model.
module tb_mcpu_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcpu_ctrl_if bus ();

  mcpu_ctrl #(.TRAP_VEC_SEL(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3;
  localparam int C_J = 4, C_IMM = 5, C_NOP = 6;

  int n_chk = 0;
  int n_fail = 0;

  int exp_q[$];
  int rdy_q[$];
  int obs_q[$];
  int cap_alu[$];
  int cap_sa[$];
  int cap_sb[$];
  int cap_ez[$];
  int cap_ps[$];
  int cap_rd[$];
  int cnt_rw, cnt_pcw, cnt_mw, cnt_mr, cnt_ir;
  int cnt_exc, cnt_rdio;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'd0:  return C_R;
      6'd35: return C_LW;
      6'd43: return C_SW;
      6'd4, 6'd5: return C_BR;
      6'd2:  return C_J;
      6'd8, 6'd9, 6'd10, 6'd11,
      6'd12, 6'd13, 6'd14: return C_IMM;
      default: return C_NOP;
    endcase
  endfunction

  function automatic int r_alu(input logic [5:0] fn);
    int fns[14] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43,
                    0, 2, 3, 24};
    int ops[14] = '{2, 12, 6, 13, 0, 1, 3, 4, 5, 7,
                    9, 8, 10, 11};
    for (int k = 0; k < 14; k++)
      if (int'(fn) == fns[k]) return ops[k];
    return 2;
  endfunction

  function automatic int i_alu(input logic [5:0] op);
    int ops[7] = '{2, 12, 5, 7, 0, 1, 3};
    return ops[int'(op) - 8];
  endfunction

  function automatic int outs_or();
    return int'(bus.pc_write | bus.ir_write | bus.reg_write |
                bus.mem_read | bus.mem_write | bus.iord |
                bus.reg_dst | bus.mem_to_reg | bus.ext_zero |
                bus.exc) +
           int'(bus.alu_src_a) + int'(bus.alu_src_b) +
           int'(bus.pc_source) + int'(bus.alu_operation) +
           int'(bus.state);
  endfunction

  task automatic push(input int s, input int r);
    exp_q.push_back(s);
    rdy_q.push_back(r < 0 ? int'($urandom_range(0, 1)) : r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one instruction from FETCH with f fetch stalls and m memory stalls.
  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input bit z, input bit ov,
                     input int f, input int m);
    int c, ai, mism, e_pcw, e_rw, e_mr, e_mw;
    bit trap;
    exp_q.delete(); rdy_q.delete(); obs_q.delete();
    cap_alu.delete(); cap_sa.delete(); cap_sb.delete();
    cap_ez.delete(); cap_ps.delete(); cap_rd.delete();
    c = cls_of(op);
    ai = (c == C_R) ? r_alu(fn) : (c == C_IMM) ? i_alu(op) : 0;
    trap = TRAP_ON && ov &&
           ((c == C_R && (ai == 2 || ai == 6)) ||
            (c == C_IMM && op == 6'd8));
    for (int i = 0; i < f; i++) push(0, 0);
    push(0, 1);
    push(1, -1);
    case (c)
      C_R:   begin push(6, -1); push(7, -1); end
      C_LW:  begin
        push(2, -1);
        for (int i = 0; i < m; i++) push(3, 0);
        push(3, 1); push(4, -1);
      end
      C_SW:  begin
        push(2, -1);
        for (int i = 0; i < m; i++) push(5, 0);
        push(5, 1);
      end
      C_BR:  push(8, -1);
      C_J:   push(9, -1);
      C_IMM: begin push(10, -1); push(11, -1); end
      default: ;
    endcase
    if (trap) push(12, -1);
    e_rw  = (c == C_R || c == C_LW || c == C_IMM) && !trap ? 1 : 0;
    e_pcw = 1 + (c == C_J ? 1 : 0) + (trap ? 1 : 0) +
            (c == C_BR && (op[0] ? !z : z) ? 1 : 0);
    e_mr  = f + 1 + (c == C_LW ? m + 1 : 0);
    e_mw  = (c == C_SW) ? m + 1 : 0;

    bus.opcode = op; bus.funct = fn;
    bus.zero = z; bus.overflow = ov;
    cnt_rw = 0; cnt_pcw = 0; cnt_mw = 0; cnt_mr = 0;
    cnt_ir = 0; cnt_exc = 0; cnt_rdio = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = rdy_q[i][0];
      @(negedge clk);
      obs_q.push_back(int'(bus.state));
      cap_alu.push_back(int'(bus.alu_operation));
      cap_sa.push_back(int'(bus.alu_src_a));
      cap_sb.push_back(int'(bus.alu_src_b));
      cap_ez.push_back(int'(bus.ext_zero));
      cap_ps.push_back(int'(bus.pc_source));
      cap_rd.push_back(int'(bus.reg_dst));
      cnt_rw  += int'(bus.reg_write);
      cnt_pcw += int'(bus.pc_write);
      cnt_mw  += int'(bus.mem_write);
      cnt_mr  += int'(bus.mem_read);
      cnt_ir  += int'(bus.ir_write);
      cnt_exc += int'(bus.exc);
      if (exp_q[i] == 3 && bus.mem_read && bus.iord) cnt_rdio++;
      @(posedge clk);
      #1;
    end
    mism = -1;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (obs_q[i] != exp_q[i]) mism = i;
    chk($sformatf("seq op=%0d fn=%0d first_bad_cycle", op, fn),
        mism, -1);
    chk("reg_write_count", cnt_rw, e_rw);
    chk("pc_write_count", cnt_pcw, e_pcw);
    chk("mem_read_count", cnt_mr, e_mr);
    chk("mem_write_count", cnt_mw, e_mw);
    chk("ir_write_count", cnt_ir, 1);
    chk("exc_count", cnt_exc, trap ? 1 : 0);
    chk("mem_rd_iord_cycles", cnt_rdio, c == C_LW ? m + 1 : 0);
    if (c == C_R || c == C_IMM) begin
      chk("exec_alu_op", cap_alu[f + 2], ai);
      chk("exec_src_a", cap_sa[f + 2],
          (c == C_R && (fn == 0 || fn == 2 || fn == 3)) ? 2 : 1);
    end
    chk("back_to_fetch", int'(bus.state), 0);
    if (bus.state != 4'd0) do_reset();
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         z;
    int         idx, st, alu, sa, sb, ez, ps, pcw, rw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int op, input int fn, input int z,
                              input int idx, input int st,
                              input int alu, input int sa,
                              input int sb, input int ez,
                              input int ps, input int pcw,
                              input int rw);
    vec_t v;
    v.op = op[5:0]; v.fn = fn[5:0]; v.z = z[0];
    v.idx = idx; v.st = st; v.alu = alu; v.sa = sa; v.sb = sb;
    v.ez = ez; v.ps = ps; v.pcw = pcw; v.rw = rw;
    return v;
  endfunction

  initial begin
    logic [5:0] op, fn;
    int ops_pick[16] = '{0, 0, 0, 35, 43, 4, 5, 2,
                         8, 9, 10, 11, 12, 13, 14, 63};
    int fns_pick[16] = '{32, 33, 34, 35, 36, 37, 38, 39,
                         42, 43, 0, 2, 3, 24, 63, 17};

    //        op  fn  z idx st alu sa sb ez ps pcw rw
    tbl.push_back(mk( 0,  0, 0, 2, 6,  9, 2, 0, 0, 0, 1, 1));
    tbl.push_back(mk( 0, 32, 0, 2, 6,  2, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk( 0, 34, 0, 2, 6,  6, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk( 0, 39, 0, 2, 6,  4, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk( 0,  3, 0, 2, 6, 10, 2, 0, 0, 0, 1, 1));
    tbl.push_back(mk( 0, 24, 0, 2, 6, 11, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk( 0, 63, 0, 2, 6,  2, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk( 8,  0, 0, 2, 10, 2, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(13,  0, 0, 2, 10, 1, 1, 2, 1, 0, 1, 1));
    tbl.push_back(mk(11,  0, 0, 2, 10, 7, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(35,  0, 0, 2, 2,  2, 1, 2, 0, 0, 1, 1));
    tbl.push_back(mk(43,  0, 0, 2, 2,  2, 1, 2, 0, 0, 1, 0));
    tbl.push_back(mk( 4,  0, 1, 2, 8,  6, 1, 0, 0, 1, 2, 0));
    tbl.push_back(mk( 5,  0, 1, 2, 8,  6, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk( 5,  0, 0, 2, 8,  6, 1, 0, 0, 1, 2, 0));
    tbl.push_back(mk( 2,  0, 0, 2, 9,  0, 0, 0, 0, 2, 2, 0));
    tbl.push_back(mk(63,  0, 0, 1, 1,  2, 0, 3, 0, 0, 1, 0));

    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    bus.overflow = 1'b0; bus.mem_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_or(), 0);
    chk("reset_mem_read", int'(bus.mem_read), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[t]) begin
      run(tbl[t].op, tbl[t].fn, tbl[t].z, 1'b0, 0, 0);
      chk($sformatf("tbl%0d state", t), obs_q[tbl[t].idx], tbl[t].st);
      chk($sformatf("tbl%0d alu", t), cap_alu[tbl[t].idx], tbl[t].alu);
      chk($sformatf("tbl%0d src_a", t), cap_sa[tbl[t].idx], tbl[t].sa);
      chk($sformatf("tbl%0d src_b", t), cap_sb[tbl[t].idx], tbl[t].sb);
      chk($sformatf("tbl%0d ext_zero", t), cap_ez[tbl[t].idx], tbl[t].ez);
      chk($sformatf("tbl%0d pc_source", t), cap_ps[tbl[t].idx], tbl[t].ps);
      chk($sformatf("tbl%0d pc_writes", t), cnt_pcw, tbl[t].pcw);
      chk($sformatf("tbl%0d reg_writes", t), cnt_rw, tbl[t].rw);
    end

    run(6'd0, 6'd0, 1'b0, 1'b0, 0, 0);
    chk("sll_rwb_reg_dst", cap_rd[3], 1);
    chk("sll_rwb_state", obs_q[3], 7);

    run(6'd35, 6'd0, 1'b0, 1'b0, 0, 2);
    chk("lw_stall_len", obs_q.size(), 7);

    run(6'd8, 6'd0, 1'b0, 1'b1, 0, 0);
    chk("addi_ovf_exc", cnt_exc, TRAP_ON ? 1 : 0);
    chk("addi_ovf_reg_write", cnt_rw, TRAP_ON ? 0 : 1);

    // Reset while a store is waiting on memory.
    bus.opcode = 6'd43; bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_wr_state", int'(bus.state), 5);
    chk("mid_wr_mem_write", int'(bus.mem_write), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_mem_write", int'(bus.mem_write), 0);
    chk("rst_wr_outputs", outs_or(), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_outputs", outs_or(), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < 300; r++) begin
      op = ops_pick[$urandom_range(0, 15)][5:0];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns_pick[$urandom_range(0, 15)][5:0];
      run(op, fn, 1'($urandom), 1'($urandom),
          $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3)),
          $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
